// File: rtl/csr_timer_pkg.sv
// Shared field positions, register offsets and defaults for the CSR timer bank.
// Optional prescaler is enabled by defining CSR_TIMER_PRESCALE_EN.
package csr_timer_pkg;
  localparam int TCFG_EN       = 0;
  localparam int TCFG_PERIODIC = 1;
  localparam int TICLR_CLR     = 0;

  localparam int OFF_TCFG    = 0;
  localparam int OFF_TVAL    = 1;
  localparam int OFF_TICLR   = 2;
  localparam int CHAN_STRIDE = 4;

  localparam int             DEF_NUM_TIMERS = 4;
  localparam int             DEF_TIMER_W    = 32;
  localparam logic [13:0]    DEF_CSR_BASE   = 14'h100;
  localparam int             DEF_PRESCALE   = 16;

  typedef enum logic [1:0] {
    REG_TCFG  = 2'(OFF_TCFG),
    REG_TVAL  = 2'(OFF_TVAL),
    REG_TICLR = 2'(OFF_TICLR),
    REG_RSVD  = 2'd3
  } reg_off_e;

  // Per-channel write request; cfg_next is the already-masked TCFG value.
  typedef struct packed {
    logic        cfg_we;
    logic        en_wr;
    logic        clr;
    logic [31:0] cfg_next;
  } chan_wr_t;
endpackage

// File: rtl/csr_timer_bank_if.sv
// CSR read/write port shared with the core CSR file.
interface csr_timer_bank_if;
  logic        csr_re;
  logic [13:0] csr_num;
  logic [31:0] csr_rvalue;
  logic        csr_hit;
  logic        csr_we;
  logic [31:0] csr_wmask;
  logic [31:0] csr_wvalue;

  modport master (
    output csr_re, csr_num, csr_we, csr_wmask, csr_wvalue,
    input  csr_rvalue, csr_hit
  );
  modport slave (
    input  csr_re, csr_num, csr_we, csr_wmask, csr_wvalue,
    output csr_rvalue, csr_hit
  );
endinterface

// File: rtl/csr_timer_chan.sv
// One timer channel: TCFG register, down counter and pending flag.
module csr_timer_chan
  import csr_timer_pkg::*;
#(
  parameter int TIMER_W = DEF_TIMER_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tick,
  input  chan_wr_t           wr,
  output logic [TIMER_W-1:0] cfg,
  output logic [TIMER_W-1:0] cnt,
  output logic               pending
);
  logic [TIMER_W-1:0] nxt, load_val, reload_val;
  logic en, periodic, zero, run, fire;

  assign nxt        = wr.cfg_next[TIMER_W-1:0];
  assign load_val   = {nxt[TIMER_W-1:2], 2'b00};
  assign reload_val = {cfg[TIMER_W-1:2], 2'b00};
  assign en         = cfg[TCFG_EN];
  assign periodic   = cfg[TCFG_PERIODIC];
  assign zero       = (cnt == '0);
  assign run        = en && tick && (cnt != '1);
  assign fire       = en && tick && zero;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cfg     <= '0;
      cnt     <= '1;
      pending <= 1'b0;
    end else begin
      if (wr.cfg_we) cfg <= nxt;
      // Only a write that actually touches EN restarts the count; a masked
      // write of other fields leaves a running count alone.
      if (wr.cfg_we && wr.en_wr && nxt[TCFG_EN])
        cnt <= load_val;
      else if (wr.cfg_we && !nxt[TCFG_EN])
        cnt <= cnt;
      else if (run)
        cnt <= (zero && periodic) ? reload_val : cnt - TIMER_W'(1);
      if (fire)        pending <= 1'b1;
      else if (wr.clr) pending <= 1'b0;
    end
  end
endmodule

// File: rtl/csr_timer_bank.sv
// Bank of NUM_TIMERS down-counting CSR timers with shared interrupt enable.
// Define CSR_TIMER_PRESCALE_EN to add a shared tick prescaler (PRESCALE).
module csr_timer_bank
  import csr_timer_pkg::*;
#(
  parameter int          NUM_TIMERS = DEF_NUM_TIMERS,
  parameter int          TIMER_W    = DEF_TIMER_W,
  parameter logic [13:0] CSR_BASE   = DEF_CSR_BASE
`ifdef CSR_TIMER_PRESCALE_EN
  , parameter int        PRESCALE   = DEF_PRESCALE
`endif
) (
  input  logic                  clk,
  input  logic                  reset,
  csr_timer_bank_if.slave       csr,
  output logic [NUM_TIMERS-1:0] timer_pending,
  output logic                  timer_irq
);
  localparam int          CW     = (NUM_TIMERS > 1) ? $clog2(NUM_TIMERS) : 1;
  localparam logic [13:0] IE_OFF = 14'(CHAN_STRIDE * NUM_TIMERS);

  logic [NUM_TIMERS-1:0][TIMER_W-1:0] cfg, cnt;
  logic [NUM_TIMERS-1:0]              ie;
  logic [13:0]                        off;
  logic                               above, in_chan, ie_sel, tick;
  logic [CW-1:0]                      chan_idx;
  reg_off_e                           roff;
  logic [31:0]                        rdata;

  // Decode relative to CSR_BASE; 'above' guards the wrapped subtraction.
  assign off      = csr.csr_num - CSR_BASE;
  assign above    = (csr.csr_num >= CSR_BASE);
  assign in_chan  = above && (off < IE_OFF);
  assign ie_sel   = above && (off == IE_OFF);
  assign chan_idx = off[CW+1:2];
  assign roff     = reg_off_e'(off[1:0]);
  assign csr.csr_hit = (in_chan && (roff != REG_RSVD)) || ie_sel;

  always_comb begin
    rdata = '0;
    if (csr.csr_re) begin
      if (ie_sel) rdata[NUM_TIMERS-1:0] = ie;
      else if (in_chan) begin
        case (roff)
          REG_TCFG: rdata[TIMER_W-1:0] = cfg[chan_idx];
          REG_TVAL: rdata[TIMER_W-1:0] = cnt[chan_idx];
          default:  rdata = '0;
        endcase
      end
    end
  end
  assign csr.csr_rvalue = rdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ie <= '0;
    else if (csr.csr_we && ie_sel)
      ie <= (csr.csr_wmask[NUM_TIMERS-1:0] & csr.csr_wvalue[NUM_TIMERS-1:0]) |
            (~csr.csr_wmask[NUM_TIMERS-1:0] & ie);
  end

  assign timer_irq = |(timer_pending & ie);

`ifdef CSR_TIMER_PRESCALE_EN
  localparam int PW = $clog2(PRESCALE);
  logic [PW-1:0] psc;
  assign tick = (psc == PW'(PRESCALE - 1));
  always_ff @(posedge clk or posedge reset) begin
    if (reset) psc <= '0;
    else       psc <= tick ? '0 : psc + PW'(1);
  end
`else
  assign tick = 1'b1;
`endif

  for (genvar i = 0; i < NUM_TIMERS; i++) begin : g_chan
    logic     sel;
    chan_wr_t wr;
    assign sel = csr.csr_we && in_chan && (chan_idx == CW'(i));
    assign wr  = '{
      cfg_we:   sel && (roff == REG_TCFG),
      en_wr:    csr.csr_wmask[TCFG_EN],
      clr:      sel && (roff == REG_TICLR) &&
                csr.csr_wmask[TICLR_CLR] && csr.csr_wvalue[TICLR_CLR],
      cfg_next: (csr.csr_wmask & csr.csr_wvalue) | (~csr.csr_wmask & 32'(cfg[i]))
    };
    csr_timer_chan #(.TIMER_W(TIMER_W)) u_chan (
      .clk     (clk),
      .reset   (reset),
      .tick    (tick),
      .wr      (wr),
      .cfg     (cfg[i]),
      .cnt     (cnt[i]),
      .pending (timer_pending[i])
    );
  end
endmodule

// File: tb/tb_csr_timer_bank.sv
// Directed, table-driven bench for csr_timer_bank (4 channels, 32-bit, base 0x100).
module tb_csr_timer_bank;
  logic       clk, reset;
  logic [3:0] pending;
  logic       irq;
  int         checks = 0;
  int         errors = 0;

  csr_timer_bank_if bus ();

  csr_timer_bank #(
    .NUM_TIMERS(4), .TIMER_W(32), .CSR_BASE(14'h100)
`ifdef CSR_TIMER_PRESCALE_EN
    , .PRESCALE(4)
`endif
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .csr           (bus.slave),
    .timer_pending (pending),
    .timer_irq     (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    bit          we;
    logic [13:0] num;
    logic [31:0] mask;
    logic [31:0] val;
    logic [31:0] exp;
    bit          exp_hit;
  } vec_t;

  vec_t vt [15];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic wr(input logic [13:0] n, input logic [31:0] m, input logic [31:0] v);
    @(negedge clk);
    bus.csr_we = 1'b1; bus.csr_num = n; bus.csr_wmask = m; bus.csr_wvalue = v;
    @(negedge clk);
    bus.csr_we = 1'b0; bus.csr_wmask = '0; bus.csr_wvalue = '0;
  endtask

  task automatic rd(input logic [13:0] n, output logic [31:0] d, output logic h);
    bus.csr_re = 1'b1; bus.csr_num = n;
    #1;
    d = bus.csr_rvalue; h = bus.csr_hit;
    bus.csr_re = 1'b0;
  endtask

  task automatic chk_rd(input string nm, input logic [13:0] n, input logic [31:0] exp);
    logic [31:0] d;
    logic        h;
    rd(n, d, h);
    chk(nm, d, exp);
  endtask

  initial begin
    logic [31:0] d;
    logic        h;
    int          n;

    vt[0]  = '{"tval0_rst",  0, 14'h101, 32'h0,        32'h0,        32'hFFFF_FFFF, 1};
    vt[1]  = '{"tval3_rst",  0, 14'h10D, 32'h0,        32'h0,        32'hFFFF_FFFF, 1};
    vt[2]  = '{"tcfg2_rst",  0, 14'h108, 32'h0,        32'h0,        32'h0,         1};
    vt[3]  = '{"ie_rst",     0, 14'h110, 32'h0,        32'h0,        32'h0,         1};
    vt[4]  = '{"rsvd",       0, 14'h103, 32'h0,        32'h0,        32'h0,         0};
    vt[5]  = '{"ticlr_rd",   0, 14'h102, 32'h0,        32'h0,        32'h0,         1};
    vt[6]  = '{"out_range",  0, 14'h111, 32'h0,        32'h0,        32'h0,         0};
    vt[7]  = '{"below_base", 0, 14'h0FF, 32'h0,        32'h0,        32'h0,         0};
    vt[8]  = '{"ie_wr",      1, 14'h110, 32'hF,        32'h5,        32'h5,         1};
    vt[9]  = '{"ie_mask",    1, 14'h110, 32'h1,        32'h0,        32'h4,         1};
    vt[10] = '{"ie_upper",   1, 14'h110, 32'hFFFF_FFFF, 32'hFFFF_FFF0, 32'h0,       1};
    vt[11] = '{"tcfg3_dis",  1, 14'h10C, 32'hFFFF_FFFF, 32'hFFFF_FFF4, 32'hFFFF_FFF4, 1};
    vt[12] = '{"tval3_hold", 0, 14'h10D, 32'h0,        32'h0,        32'hFFFF_FFFF, 1};
    vt[13] = '{"tval_ro",    1, 14'h101, 32'hFFFF_FFFF, 32'h0,       32'hFFFF_FFFF, 1};
    vt[14] = '{"tcfg3_clr",  1, 14'h10C, 32'hFFFF_FFFF, 32'h0,       32'h0,         1};

    bus.csr_re = 0; bus.csr_num = '0; bus.csr_we = 0; bus.csr_wmask = '0; bus.csr_wvalue = '0;
    reset = 1'b1;
    #1;
    chk("rst_pending", 32'(pending), 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    chk("rst_rvalue", bus.csr_rvalue, 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 15; i++) begin
      if (vt[i].we) wr(vt[i].num, vt[i].mask, vt[i].val);
      rd(vt[i].num, d, h);
      chk(vt[i].name, d, vt[i].exp);
      chk({vt[i].name, "_hit"}, 32'(h), 32'(vt[i].exp_hit));
    end
    chk("tbl_pending", 32'(pending), 32'h0);

`ifndef CSR_TIMER_PRESCALE_EN
    // one-shot, channel 1, INITVAL=2
    wr(14'h104, 32'hFFFF_FFFF, 32'h9);
    for (int k = 8; k >= 0; k--) begin
      chk_rd("os_tval", 14'h105, 32'(k));
      chk("os_pend_lo", 32'(pending[1]), 32'h0);
      @(negedge clk);
    end
    chk("os_pend_hi", 32'(pending[1]), 32'h1);
    chk_rd("os_idle", 14'h105, 32'hFFFF_FFFF);
    repeat (3) @(negedge clk);
    chk_rd("os_idle_hold", 14'h105, 32'hFFFF_FFFF);
    chk("os_pend_hold", 32'(pending[1]), 32'h1);
    wr(14'h106, 32'h1, 32'h1);
    chk("os_clr", 32'(pending[1]), 32'h0);

    // periodic, channel 0, with IE
    wr(14'h110, 32'hFFFF_FFFF, 32'h1);
    wr(14'h100, 32'hFFFF_FFFF, 32'hB);
    repeat (8) @(negedge clk);
    chk("per_pend_lo", 32'(pending[0]), 32'h0);
    chk_rd("per_tval0", 14'h101, 32'h0);
    @(negedge clk);
    chk("per_pend_hi", 32'(pending[0]), 32'h1);
    chk("per_irq_hi", 32'(irq), 32'h1);
    chk_rd("per_reload", 14'h101, 32'h8);
    wr(14'h102, 32'h1, 32'h1);
    chk("per_clr", 32'(pending[0]), 32'h0);
    chk("per_irq_lo", 32'(irq), 32'h0);
    chk_rd("per_tval6", 14'h101, 32'h6);
    repeat (5) @(negedge clk);
    wr(14'h102, 32'h1, 32'h1);
    chk("per_set_wins", 32'(pending[0]), 32'h1);
    chk("per_irq_again", 32'(irq), 32'h1);
    chk_rd("per_reload2", 14'h101, 32'h8);

    // disable freezes count, pending untouched
    wr(14'h100, 32'hFFFF_FFFF, 32'h8);
    chk_rd("dis_tval", 14'h101, 32'h7);
    repeat (3) @(negedge clk);
    chk_rd("dis_frozen", 14'h101, 32'h7);
    chk_rd("dis_tcfg", 14'h100, 32'h8);
    chk("dis_pend", 32'(pending[0]), 32'h1);
    wr(14'h102, 32'h1, 32'h1);

    // masked write sets PERIODIC without reload
    wr(14'h104, 32'hFFFF_FFFF, 32'h11);
    repeat (2) @(negedge clk);
    chk_rd("msk_pre", 14'h105, 32'd14);
    wr(14'h104, 32'h2, 32'h2);
    chk_rd("msk_tcfg", 14'h104, 32'h13);
    chk_rd("msk_tval", 14'h105, 32'd12);
    repeat (13) @(negedge clk);
    chk("msk_pend", 32'(pending[1]), 32'h1);
    chk_rd("msk_reload", 14'h105, 32'd16);
    wr(14'h104, 32'hFFFF_FFFF, 32'h0);
    wr(14'h106, 32'h1, 32'h1);

    // INITVAL=0 periodic, channel 2
    wr(14'h108, 32'hFFFF_FFFF, 32'h3);
    chk_rd("z_per_tval", 14'h109, 32'h0);
    chk("z_per_pend0", 32'(pending[2]), 32'h0);
    @(negedge clk);
    chk("z_per_pend1", 32'(pending[2]), 32'h1);
    wr(14'h108, 32'hFFFF_FFFF, 32'h0);
    wr(14'h10A, 32'h1, 32'h1);
    chk("z_per_clr", 32'(pending[2]), 32'h0);

    // INITVAL=0 one-shot, channel 3
    wr(14'h10C, 32'hFFFF_FFFF, 32'h1);
    chk_rd("z_os_tval", 14'h10D, 32'h0);
    chk("z_os_pend0", 32'(pending[3]), 32'h0);
    @(negedge clk);
    chk("z_os_pend1", 32'(pending[3]), 32'h1);
    chk_rd("z_os_idle", 14'h10D, 32'hFFFF_FFFF);
    repeat (2) @(negedge clk);
    chk_rd("z_os_idle2", 14'h10D, 32'hFFFF_FFFF);
    wr(14'h10E, 32'h1, 32'h1);
`endif

    // tick latency, INITVAL=1 one-shot on channel 2
    wr(14'h108, 32'hFFFF_FFFF, 32'h5);
    n = 0;
    while (!pending[2] && n < 100) begin
      @(negedge clk);
      n++;
    end
`ifdef CSR_TIMER_PRESCALE_EN
    chk("psc_latency_window", 32'(n >= 17 && n <= 23), 32'h1);
`else
    chk("tick_latency", 32'(n), 32'd5);
`endif

    // asynchronous reset mid-count
    wr(14'h110, 32'hFFFF_FFFF, 32'h1);
    wr(14'h100, 32'hFFFF_FFFF, 32'hB);
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_pend", 32'(pending), 32'h0);
    chk("mid_rst_irq", 32'(irq), 32'h0);
    for (int c = 0; c < 4; c++)
      chk_rd("mid_rst_tval", 14'h101 + 14'(4 * c), 32'hFFFF_FFFF);
    chk_rd("mid_rst_tcfg0", 14'h100, 32'h0);
    chk_rd("mid_rst_ie", 14'h110, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
